// File: rtl/fsqrt_ctrl_pkg.sv
// Shared definitions for the fsqrt request controller: defaults, the quiet-NaN
// constant returned for negative operands, and the tag-pipe entry layout.
package fsqrt_ctrl_pkg;

    localparam int TAG_W_DEF = 6;
    localparam int DEPTH_DEF = 4;
    localparam int LAT_DEF   = 3;

    // Tag field in the pipe entry is sized for the widest tag supported;
    // narrower tags are zero-extended on entry and truncated on exit.
    localparam int TAG_MAX_W = 16;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic                 valid;
        logic                 nan;
        logic [TAG_MAX_W-1:0] tag;
    } pipe_entry_t;

    // True for any negative operand other than -0.0; those have no real root.
    function automatic logic is_neg_nonzero(input logic [31:0] f);
        return f[31] & (|f[30:0]);
    endfunction

endpackage

// File: rtl/fsqrt_ctrl_chk.sv
// Protocol checks for fsqrt_ctrl; carries no functional logic.
module fsqrt_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic fifo_push,
    input logic fifo_full
);

    // Credit accounting means a full FIFO implies nothing is in flight.
    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full));

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Push is accepted on a full FIFO only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fsqrt_ctrl.sv
// Front end for a fixed-latency fsqrt pipe: issues operands with credit-based
// flow control, tracks tags alongside the pipe, substitutes a quiet NaN for
// negative operands, and buffers results in order for a ready/valid consumer.
module fsqrt_ctrl
    import fsqrt_ctrl_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sqrt_a,
    output logic             sqrt_valid,
    input  logic [31:0]      sqrt_result,
    input  logic             sqrt_out_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FW    = 32 + TAG_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] credit_r;
    pipe_entry_t      pipe_r [LAT];
    pipe_entry_t      new_entry_s;
    pipe_entry_t      head_s;
    logic             err_r;

    logic             accept_s;
    logic             pop_s;
    logic             neg_nz_s;
    logic             push_s;
    logic [31:0]      push_data_s;
    logic             err_set_s;
    logic [FW-1:0]    fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             tag_unused_s;

    // Request side: a credit freed by this cycle's pop may be reused at once,
    // which is what lets a full controller keep streaming one per cycle.
    assign neg_nz_s   = is_neg_nonzero(in_data);
    assign out_valid  = ~rst & ~fifo_empty_s;
    assign pop_s      = out_valid & out_ready;
    assign in_ready   = ~rst & ((credit_r < DEPTH_C) | pop_s);
    assign accept_s   = in_valid & in_ready;
    assign sqrt_a     = in_data;
    assign sqrt_valid = accept_s & ~neg_nz_s;
    assign err        = err_r;

    assign new_entry_s.valid = accept_s;
    assign new_entry_s.nan   = neg_nz_s;
    assign new_entry_s.tag   = TAG_MAX_W'(in_tag);
    assign head_s            = pipe_r[LAT-1];
    assign tag_unused_s      = ^head_s.tag;

    // Credits = requests in the pipe plus results waiting in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credit_r <= credit_r + CNT_W'(1);
                2'b01:   credit_r <= credit_r - CNT_W'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Tag pipe mirrors the fsqrt latency and never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= new_entry_s;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Pipe exit: every valid entry is pushed so ordering and credits stay
    // consistent even if the fsqrt handshake is broken; mismatches raise err.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = '0;
        err_set_s   = 1'b0;
        if (head_s.valid && head_s.nan) begin
            push_s      = 1'b1;
            push_data_s = QNAN;
            err_set_s   = sqrt_out_valid;
        end else if (head_s.valid) begin
            push_s      = 1'b1;
            push_data_s = sqrt_result;
            err_set_s   = ~sqrt_out_valid;
        end else begin
            err_set_s   = sqrt_out_valid;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({push_data_s, head_s.tag[TAG_W-1:0]}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Result outputs are zero whenever no result is presented.
    always_comb begin
        if (out_valid) begin
            out_data = fifo_rdata_s[FW-1:TAG_W];
            out_tag  = fifo_rdata_s[TAG_W-1:0];
        end else begin
            out_data = '0;
            out_tag  = '0;
        end
    end

    fsqrt_ctrl_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .fifo_push (push_s),
        .fifo_full (fifo_full_s)
    );

endmodule

// File: tb/tb_fsqrt_ctrl.sv
// Bench for fsqrt_ctrl: a stand-in fsqrt pipe plus a transaction-level
// scoreboard (accept time, ready time, expected result) checked every cycle.
`timescale 1ns/1ps
module tb_fsqrt_ctrl;
    import fsqrt_ctrl_pkg::*;

    localparam int TAG_W = 6;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'h0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      sqrt_a;
    logic             sqrt_valid;
    logic [31:0]      sqrt_result;
    logic             sqrt_out_valid;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             err;
    logic             force_sov = 1'b0;

    always #5 clk = ~clk;

    fsqrt_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .sqrt_a(sqrt_a), .sqrt_valid(sqrt_valid),
        .sqrt_result(sqrt_result), .sqrt_out_valid(sqrt_out_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .err(err)
    );

    // Stand-in root: exact for the directed perfect squares, otherwise an
    // arbitrary fingerprint of the operand (the controller is data-agnostic).
    function automatic logic [31:0] fake_sqrt(input logic [31:0] a);
        case (a)
            32'h3F80_0000: return 32'h3F80_0000;
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h8000_0000: return 32'h8000_0000;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Fixed-latency fsqrt stand-in, reset together with the controller.
    logic [31:0] fs_data_r [LAT];
    logic        fs_vld_r  [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                fs_vld_r[i]  <= 1'b0;
                fs_data_r[i] <= 32'h0;
            end
        end else begin
            fs_vld_r[0]  <= sqrt_valid;
            fs_data_r[0] <= fake_sqrt(sqrt_a);
            for (int i = 1; i < LAT; i++) begin
                fs_vld_r[i]  <= fs_vld_r[i-1];
                fs_data_r[i] <= fs_data_r[i-1];
            end
        end
    end
    assign sqrt_out_valid = fs_vld_r[LAT-1] | force_sov;
    assign sqrt_result    = fs_data_r[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every accepted request is owed back in order, no earlier
    // than LAT+1 cycles after the accepting cycle.
    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } exp_t;
    exp_t             exp_q[$];
    logic [31:0]      pop_log[$];
    int               cyc = 0;
    int               sv_cnt = 0;
    int               both_cnt = 0;
    logic             hold_prev = 1'b0;
    logic [31:0]      prev_data = 32'h0;
    logic [TAG_W-1:0] prev_tag = '0;

    task automatic monitor_cycle();
        logic exp_ov, exp_ir, acc, pop, nnz;
        cyc++;
        exp_ov = !rst && (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
        exp_ir = !rst && ((exp_q.size() < DEPTH) || (exp_ov && out_ready));
        check_eq("out_valid", out_valid, exp_ov);
        check_eq("in_ready", in_ready, exp_ir);
        acc = in_valid && exp_ir;
        nnz = in_data[31] && (in_data[30:0] != 31'h0);
        check_eq("sqrt_valid", sqrt_valid, acc && !nnz);
        if (acc && !nnz) check_eq("sqrt_a", sqrt_a, in_data);
        if (sqrt_valid) sv_cnt++;
        if (in_valid && in_ready && out_valid && out_ready) both_cnt++;
        if (rst) begin
            check_eq("rst_out_data", out_data, 64'h0);
            check_eq("rst_out_tag", out_tag, 64'h0);
        end
        if (hold_prev && !rst) begin
            check_eq("hold_data", out_data, prev_data);
            check_eq("hold_tag", out_tag, prev_tag);
        end
        pop = exp_ov && out_ready;
        if (pop) begin
            check_eq("pop_data", out_data, exp_q[0].data);
            check_eq("pop_tag", out_tag, exp_q[0].tag);
            pop_log.push_back(out_data);
            void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back('{nnz ? QNAN : fake_sqrt(in_data), in_tag, cyc + LAT + 1});
        if (rst) exp_q.delete();
        hold_prev = exp_ov && !out_ready;
        prev_data = out_data;
        prev_tag  = out_tag;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_cycle();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle, then measure cycles to out_valid.
    task automatic send_one(input logic [31:0] d, input logic [TAG_W-1:0] t, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_drained(input string tag);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
        check_eq(tag, exp_q.size(), 64'h0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return {1'b1, 31'($urandom)};
            2:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    int lat;
    int sv0;

    initial begin
        // Reset state.
        repeat (3) tick();
        check_eq("rst_err", err, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", in_ready, 64'h1);
        tick();

        // Single 4.0 request, tag 5.
        out_ready = 1'b1;
        sv0 = sv_cnt;
        send_one(32'h4080_0000, 6'd5, lat);
        check_eq("lat_4p0", lat, LAT + 1);
        check_eq("data_4p0", out_data, 64'h4000_0000);
        check_eq("tag_4p0", out_tag, 64'd5);
        check_eq("sv_4p0", sv_cnt - sv0, 64'd1);
        tick();

        // Negative operand -4.0, tag 9: no issue, NaN returned on time.
        sv0 = sv_cnt;
        send_one(32'hC080_0000, 6'd9, lat);
        check_eq("lat_neg", lat, LAT + 1);
        check_eq("data_neg", out_data, {32'h0, QNAN});
        check_eq("tag_neg", out_tag, 64'd9);
        check_eq("sv_neg", sv_cnt - sv0, 64'd0);
        tick();

        // Back-to-back squares with the consumer stalled.
        out_ready = 1'b0;
        pop_log.delete();
        in_data = 32'h3F80_0000; in_tag = 6'd1; in_valid = 1'b1; tick();
        in_data = 32'h4080_0000; in_tag = 6'd2; tick();
        in_data = 32'h4110_0000; in_tag = 6'd3; tick();
        in_data = 32'h4180_0000; in_tag = 6'd4; tick();
        in_data = 32'h41C8_0000; in_tag = 6'd7;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check_eq("full_ready", in_ready, 64'h0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && pop_log.size() < 4; n++) tick();
        check_eq("pop_count", pop_log.size(), 64'd4);
        if (pop_log.size() == 4) begin
            check_eq("pop0", pop_log[0], 64'h3F80_0000);
            check_eq("pop1", pop_log[1], 64'h4000_0000);
            check_eq("pop2", pop_log[2], 64'h4040_0000);
            check_eq("pop3", pop_log[3], 64'h4080_0000);
        end

        // Full controller streaming: accept and pop in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int n = 0; n < DEPTH; n++) begin
            in_data = rand_op(); in_tag = TAG_W'($urandom); tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        both_cnt  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_data = rand_op(); in_tag = TAG_W'($urandom); tick();
        end
        in_valid = 1'b0;
        check_eq("stream_both", both_cnt, 64'd16);
        wait_drained("drain_stream");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            in_data   = rand_op();
            in_tag    = TAG_W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drained("drain_random");
        check_eq("err_clean", err, 64'h0);

        // Stray fsqrt result with an empty tag pipe.
        repeat (LAT + 2) tick();
        force_sov = 1'b1;
        tick();
        force_sov = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_eq("err_sticky", err, 64'h1);
            check_eq("stray_not_pushed", out_valid, 64'h0);
            tick();
        end

        // Reset while three requests are in flight.
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_data = rand_op(); in_tag = TAG_W'($urandom); tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_mid_rst", in_ready, 64'h1);
        check_eq("err_after_rst", err, 64'h0);
        for (int n = 0; n < 10; n++) begin
            tick();
            @(negedge clk);
            check_eq("no_out_after_rst", out_valid, 64'h0);
        end
        check_eq("err_after_flush", err, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fsqrt_ctrl.md
FSQRT_CTRL -- requirements
Module: fsqrt_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 6, the destination tag width.
REQ-002 SHALL have parameter DEPTH, default 4, the result FIFO depth and the in-flight credit limit.
REQ-003 SHALL have parameter LAT, default 3, the fixed latency of the downstream fsqrt pipe.
REQ-004 SHALL have port clk, input, 1: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset, shared with the attached fsqrt.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, 32: IEEE-754 single operand.
REQ-009 SHALL have port in_tag, input, TAG_W: destination tag.
REQ-010 SHALL have port sqrt_a, output, 32: operand to fsqrt input_a.
REQ-011 SHALL have port sqrt_valid, output, 1: to fsqrt input_valid.
REQ-012 SHALL have port sqrt_result, input, 32: from fsqrt result.
REQ-013 SHALL have port sqrt_out_valid, input, 1: from fsqrt out_valid.
REQ-014 SHALL have port out_valid, output, 1: result available.
REQ-015 SHALL have port out_ready, input, 1: consumer takes result when out_valid && out_ready.
REQ-016 SHALL have port out_data, output, 32: result.
REQ-017 SHALL have port out_tag, output, TAG_W: tag of out_data.
REQ-018 SHALL have port err, output, 1: sticky protocol-mismatch flag.

Function
REQ-019 SHALL count credits: in_ready = (in-flight + FIFO occupancy) < DEPTH; accept increments, pop decrements, simultaneous accept and pop leaves the count unchanged.
REQ-020 SHALL, on accept, drive sqrt_a = in_data and sqrt_valid = 1 combinationally in the same cycle, unless the operand is negative-nonzero (sign=1 and bits[30:0] != 0).
REQ-021 SHALL, for a negative-nonzero operand, hold sqrt_valid low and mark the entry NaN; -0.0 (0x80000000) is issued normally.
REQ-022 SHALL carry {valid, nan, tag} through an LAT-stage shift register advancing every cycle, never stalling.
REQ-023 SHALL, at stage LAT, push {sqrt_result, tag} when the entry is valid and not NaN, and push {0x7FC00000, tag} when the entry is valid and NaN.
REQ-024 SHALL, at stage LAT, set err if a valid non-NaN entry arrives without sqrt_out_valid, or if sqrt_out_valid arrives without a valid non-NaN entry; such a stray result is dropped.
REQ-025 SHALL give a total latency of LAT+1 cycles: a request accepted in cycle t is pushed at the end of cycle t+LAT, and out_valid is high in cycle t+LAT+1 if the FIFO was empty.
REQ-026 SHALL return results in strict acceptance order, with out_data and out_tag stable while out_valid && !out_ready.
REQ-027 SHALL support simultaneous push and pop on a full FIFO; the credit rule of REQ-019 guarantees a push never meets a full FIFO (assertion).
REQ-028 SHALL sustain 1 request per cycle with out_ready held high.

Reset
REQ-029 SHALL, while rst is high, clear the credit count, the tag pipe, the FIFO pointers and err, and drive in_ready=0, sqrt_valid=0, out_valid=0, out_data=0 and out_tag=0.
REQ-030 SHALL discard everything in flight on a reset mid-operation; fsqrt is reset by the same rst, so no stray results follow.
REQ-031 SHALL assert in_ready in the first cycle after rst falls.

Structure
REQ-032 SHALL keep TAG_W/DEPTH/LAT defaults, the QNAN constant 0x7FC00000, and the tag-pipe entry struct {valid, nan, tag} in package fsqrt_ctrl_pkg.
REQ-033 SHALL implement the result FIFO as sub-module sync_fifo (parameterised width/depth, synchronous active-high rst, push/pop/full/empty).

Verification
REQ-034 SHALL cover: single request 0x40800000 (4.0), tag 5 -> out_data 0x40000000, out_tag 5, out_valid in cycle t+4.
REQ-035 SHALL cover: 0xC0800000 (-4.0), tag 9 -> sqrt_valid never high, out_data 0x7FC00000, tag 9, at t+4.
REQ-036 SHALL cover: back-to-back requests 1.0, 4.0, 9.0, 16.0 with out_ready=0 -> in_ready low after 4 accepts; after out_ready=1, results 0x3F800000, 0x40000000, 0x40400000, 0x40800000 pop in order.
REQ-037 SHALL cover: full with out_ready=1 and in_valid held -> accept and pop in the same cycle, credits stay at 4, no loss or duplication.
REQ-038 SHALL cover: sqrt_out_valid forced high with an empty tag pipe -> err=1 and stays 1; nothing pushed.
REQ-039 SHALL cover: rst pulsed while 3 requests are in flight -> out_valid stays 0 afterwards, err=0, in_ready=1 one cycle after release.
